// File: rtl/memo_dp.sv
// memo_dp: dual-port synchronous data memory.
// Port A reads and writes with byte-lane enables. Port B is read-only.
// After reset or a clr request, a built-in sequencer fills the whole array
// with zeros or an address pattern before the ports are opened (ready=1).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_INIT | fill pass: one word per edge, ports ignored, q_a/q_b held at 0
// S_RUN  | normal operation: port A read/write, port B read
module memo_dp #(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter int INIT_MODE = 0,
  parameter int RDW_MODE  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  output logic              ready,
  input  logic [AW-1:0]     address_a,
  input  logic [DW-1:0]     data_a,
  input  logic [DW/8-1:0]   byteena_a,
  input  logic              wren_a,
  output logic [DW-1:0]     q_a,
  input  logic [AW-1:0]     address_b,
  output logic [DW-1:0]     q_b
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [DW-1:0]   mem [0:DEPTH-1];

  logic [DW-1:0]   old_a;
  logic [DW-1:0]   old_b;
  logic [DW-1:0]   merged_a;
  logic [DW-1:0]   fill_word;
  logic [7:0]      fill_byte;
  logic            user_we;
  logic            collide_b;

  // Pattern byte is the low 8 bits of the fill address; it repeats every 256 words.
  if (AW >= 8) begin : g_fill_wide
    assign fill_byte = cnt[7:0];
  end else begin : g_fill_narrow
    assign fill_byte = {{(8-AW){1'b0}}, cnt};
  end

  assign old_a     = mem[address_a];
  assign old_b     = mem[address_b];
  assign user_we   = (state == S_RUN) && wren_a && (|byteena_a);
  assign collide_b = (state == S_RUN) && wren_a && (address_b == address_a);

  // Lane merge of the port A write data over the currently stored word.
  always_comb begin
    merged_a = old_a;
    for (int k = 0; k < NB; k++) begin
      if (byteena_a[k]) merged_a[8*k +: 8] = data_a[8*k +: 8];
    end
  end

  // Fill value for the word at the current sequencer address.
  always_comb begin
    fill_word = '0;
    if (INIT_MODE == 1) begin
      for (int k = 0; k < NB; k++) fill_word[8*k +: 8] = fill_byte;
    end
  end

  // Array write port: sequencer owns it during INIT, port A during RUN.
  // The array itself is never reset; the fill pass overwrites it.
  always_ff @(posedge clock) begin
    if (state == S_INIT) begin
      mem[cnt] <= fill_word;
    end else if (user_we) begin
      mem[address_a] <= merged_a;
    end
  end

  // Sequencer FSM with registered ready and read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
      ready <= 1'b0;
      q_a   <= '0;
      q_b   <= '0;
    end else begin
      case (state)
        S_INIT: begin
          q_a <= '0;
          q_b <= '0;
          cnt <= cnt + 1'b1;
          if (cnt == {AW{1'b1}}) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: begin
          q_a <= (RDW_MODE == 1 && wren_a) ? merged_a : old_a;
          q_b <= (RDW_MODE == 1 && collide_b) ? merged_a : old_b;
          // A write issued alongside clr still lands; the fill overwrites it later.
          if (clr) begin
            state <= S_INIT;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= S_INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memo_dp.sv
// Directed bench for memo_dp. Two instances share all inputs:
// d0 = zero fill / old-data RDW, d1 = pattern fill / new-data RDW.
module tb_memo_dp;

  logic        clock;
  logic        reset;
  logic        clr;
  logic [5:0]  address_a;
  logic [31:0] data_a;
  logic [3:0]  byteena_a;
  logic        wren_a;
  logic [5:0]  address_b;
  logic        ready0, ready1;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;

  int n_checks = 0;
  int n_fails  = 0;

  memo_dp #(.AW(6), .DW(32), .INIT_MODE(0), .RDW_MODE(0)) d0 (
    .clock(clock), .reset(reset), .clr(clr), .ready(ready0),
    .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a),
    .wren_a(wren_a), .q_a(q_a0), .address_b(address_b), .q_b(q_b0)
  );

  memo_dp #(.AW(6), .DW(32), .INIT_MODE(1), .RDW_MODE(1)) d1 (
    .clock(clock), .reset(reset), .clr(clr), .ready(ready1),
    .address_a(address_a), .data_a(data_a), .byteena_a(byteena_a),
    .wren_a(wren_a), .q_a(q_a1), .address_b(address_b), .q_b(q_b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rep(input logic [7:0] b);
    return {4{b}};
  endfunction

  task automatic check_idle(input string tag, input logic exp_ready);
    check({tag, " ready0"}, {31'd0, ready0}, {31'd0, exp_ready});
    check({tag, " ready1"}, {31'd0, ready1}, {31'd0, exp_ready});
    check({tag, " q_a0"}, q_a0, 32'h0);
    check({tag, " q_b0"}, q_b0, 32'h0);
    check({tag, " q_a1"}, q_a1, 32'h0);
    check({tag, " q_b1"}, q_b1, 32'h0);
  endtask

  initial begin
    logic [5:0] ab;
    reset     = 1'b1;
    clr       = 1'b0;
    address_a = 6'h00;
    data_a    = 32'h0;
    byteena_a = 4'h0;
    wren_a    = 1'b0;
    address_b = 6'h00;

    // Reset held for three cycles.
    tick(); tick(); tick();
    check_idle("reset", 1'b0);

    // Init pass: user writes and clr must be ignored for all 64 edges.
    address_a = 6'h05; data_a = 32'hFFFFFFFF; byteena_a = 4'hF; wren_a = 1'b1;
    address_b = 6'h3F; clr = 1'b1;
    reset = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check_idle("init", (i == 64));
    end
    wren_a = 1'b0; clr = 1'b0; byteena_a = 4'h0;

    // Sweep: every address on both ports.
    for (int i = 0; i < 64; i++) begin
      address_a = 6'(i);
      address_b = 6'(63 - i);
      tick();
      ab = 6'(63 - i);
      check("sweep q_a0", q_a0, 32'h0);
      check("sweep q_b0", q_b0, 32'h0);
      check("sweep q_a1", q_a1, rep({2'b00, address_a}));
      check("sweep q_b1", q_b1, rep({2'b00, ab}));
    end

    // Byte lanes at 0x10.
    address_a = 6'h10; address_b = 6'h11;
    data_a = 32'hDEADBEEF; byteena_a = 4'hF; wren_a = 1'b1;
    tick();
    check("bl full q_a0", q_a0, 32'h00000000);
    check("bl full q_a1", q_a1, 32'hDEADBEEF);
    data_a = 32'h11223344; byteena_a = 4'h5;
    tick();
    check("bl 0101 q_a0", q_a0, 32'hDEADBEEF);
    check("bl 0101 q_a1", q_a1, 32'hDE22BE44);
    wren_a = 1'b0; address_b = 6'h10;
    tick();
    check("bl rd q_a0", q_a0, 32'hDE22BE44);
    check("bl rd q_a1", q_a1, 32'hDE22BE44);
    check("bl rd q_b0", q_b0, 32'hDE22BE44);
    check("bl rd q_b1", q_b1, 32'hDE22BE44);
    data_a = 32'h00000000; byteena_a = 4'h0; wren_a = 1'b1;
    tick();
    check("bl 0000 q_a0", q_a0, 32'hDE22BE44);
    check("bl 0000 q_a1", q_a1, 32'hDE22BE44);
    wren_a = 1'b0;
    tick();
    check("bl after0 q_a0", q_a0, 32'hDE22BE44);
    check("bl after0 q_a1", q_a1, 32'hDE22BE44);

    // Read-during-write collision at 0x20.
    address_a = 6'h20; address_b = 6'h21;
    data_a = 32'hAAAAAAAA; byteena_a = 4'hF; wren_a = 1'b1;
    tick();
    data_a = 32'h55555555; address_b = 6'h20;
    tick();
    check("rdw q_a0", q_a0, 32'hAAAAAAAA);
    check("rdw q_b0", q_b0, 32'hAAAAAAAA);
    check("rdw q_a1", q_a1, 32'h55555555);
    check("rdw q_b1", q_b1, 32'h55555555);
    wren_a = 1'b0;
    tick();
    check("rdw after q_a0", q_a0, 32'h55555555);
    check("rdw after q_b0", q_b0, 32'h55555555);
    check("rdw after q_b1", q_b1, 32'h55555555);

    // clr together with a write to 0x08; clr pulse during the fill is ignored.
    address_a = 6'h08; address_b = 6'h08;
    data_a = 32'h12345678; byteena_a = 4'hF; wren_a = 1'b1; clr = 1'b1;
    tick();
    check("clr ready0", {31'd0, ready0}, 32'd0);
    check("clr ready1", {31'd0, ready1}, 32'd0);
    wren_a = 1'b0; clr = 1'b0; byteena_a = 4'h0;
    for (int i = 1; i <= 64; i++) begin
      clr = (i == 10);
      tick();
      check_idle("clr init", (i == 64));
    end
    clr = 1'b0;
    tick();
    check("clr fill q_a0", q_a0, 32'h00000000);
    check("clr fill q_a1", q_a1, 32'h08080808);
    check("clr fill q_b1", q_b1, 32'h08080808);

    // Reset at init edge 30 restarts the full fill.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    address_a = 6'h2A; address_b = 6'h15;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check_idle("pre-rst init", 1'b0);
    end
    reset = 1'b1;
    #1;
    check_idle("async rst", 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check_idle("re-init", (i == 64));
    end
    tick();
    check("re-init q_a1", q_a1, 32'h2A2A2A2A);
    check("re-init q_b1", q_b1, 32'h15151515);
    check("re-init q_a0", q_a0, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
